// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO beside the EX-stage ALU.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply path.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mf_req,
  input  logic             mf_sel,
  input  logic             mt_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               dz;
  logic               neg_p;
  logic               neg_r;

  logic               sa, sb, dz_in, fast;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc_init;

  assign sa    = ~op[0] & src_a[WIDTH-1];
  assign sb    = ~op[0] & src_b[WIDTH-1];
  assign abs_a = sa ? -src_a : src_a;
  assign abs_b = sb ? -src_b : src_b;
  assign dz_in = op[1] & (src_b == '0);

`ifdef MULDIV_FAST_MULT_EN
  assign fast     = ~op[1];
  assign acc_init = fast
    ? {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b}
    : {{WIDTH{1'b0}}, abs_a};
`else
  assign fast     = 1'b0;
  assign acc_init = {{WIDTH{1'b0}}, abs_a};
`endif

  // acc holds {partial product} for mul, {remainder, quotient} for div
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
  assign div_next = div_diff[WIDTH]
    ? {acc[2*WIDTH-2:0], 1'b0}
    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign quo_fix  = neg_p ? -quo : quo;
  assign rem_fix  = neg_r ? -rem : rem;
  assign prod_fix = neg_p ? -acc : acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = (dz_in | fast) ? FIXUP : RUN;
      RUN:   if (cnt == LAST) state_nx = FIXUP;
      FIXUP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi          <= '0;
      lo          <= '0;
      acc         <= '0;
      opb         <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      neg_p       <= 1'b0;
      neg_r       <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            dz     <= dz_in;
            neg_p  <= sa ^ sb;
            neg_r  <= sa;
            cnt    <= '0;
            opb    <= abs_b;
            acc    <= dz_in ? {src_a, {WIDTH{1'b1}}} : acc_init;
          end else if (mt_we) begin
            if (mf_sel) hi <= mt_data;
            else        lo <= mt_data;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          acc <= is_div ? div_next : mul_next;
        end
        FIXUP: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          if (dz) begin
            {hi, lo} <= acc;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign stall_req = busy & (start | mf_req | mt_we);
  assign mf_data   = mf_sel ? hi : lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Random + directed bench for muldiv_sequencer against a transaction-level model.
// Define MULDIV_FAST_MULT_EN to match a fast-multiply build.
module tb_muldiv_sequencer;
  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         mf_req = 1'b0;
  logic         mf_sel = 1'b0;
  logic         mt_we = 1'b0;
  logic [W-1:0] mt_data = '0;
  logic         busy, stall_req, done, div_by_zero;
  logic [W-1:0] mf_data, hi, lo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .mf_req(mf_req), .mf_sel(mf_sel),
    .mt_we(mt_we), .mt_data(mt_data),
    .busy(busy), .stall_req(stall_req), .mf_data(mf_data),
    .hi(hi), .lo(lo), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic void calc(input logic [1:0] o,
                               input logic [W-1:0] a, b,
                               output logic [W-1:0] h, l,
                               output logic z);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'd0: begin p = 64'(sa * sb); {h, l} = p; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; end
      default: begin
        if (b == '0) begin
          z = 1'b1; h = a; l = '1;
        end else if (o == 2'd2) begin
          q = sa / sb; r = sa % sb;
          l = q[W-1:0]; h = r[W-1:0];
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  bit           armed = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_done = 0, m_dz = 0, p_dz = 0;
  int           m_left = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed = 1; m_hi = '0; m_lo = '0;
      m_left = 0; m_done = 0; m_dz = 0;
    end else begin
      m_done = 0;
      m_dz = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo;
          m_done = 1; m_dz = p_dz;
        end
      end else if (start) begin
        calc(op, src_a, src_b, p_hi, p_lo, p_dz);
        m_left = (p_dz || (FAST && !op[1])) ? 1 : W + 1;
      end else if (mt_we) begin
        if (mf_sel) m_hi = mt_data;
        else        m_lo = mt_data;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", busy, m_left > 0);
      chk("stall_req", stall_req,
          (m_left > 0) && (start || mf_req || mt_we));
      chk("done", done, m_done);
      chk("div_by_zero", div_by_zero, m_dz);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("mf_data", mf_data, mf_sel ? m_hi : m_lo);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int c0;

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick;
    c0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lat);
    bit ok;
    ok = 0;
    for (int i = 0; i < W + 10; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk({nm, "_done"}, ok, 1'b1);
    chk({nm, "_latency"}, cyc - c0, lat);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  localparam int MUL_LAT = FAST ? 1 : W + 1;
  bit seen;

  initial begin
    rst = 1'b1;
    repeat (2) tick;
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick;
    rst = 1'b0;

    issue(2'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done("t1", MUL_LAT);
    chk("t1_hi", hi, 32'h1);
    chk("t1_lo", lo, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_busy", busy, 0);

    issue(2'd0, -32'sd3, 32'd7);
    wait_done("t2m", MUL_LAT);
    chk("t2m_hi", hi, 32'hFFFF_FFFF);
    chk("t2m_lo", lo, 32'hFFFF_FFEB);

    issue(2'd2, -32'sd7, 32'd2);
    wait_done("t2d", W + 1);
    chk("t2d_lo", lo, 32'hFFFF_FFFD);
    chk("t2d_hi", hi, 32'hFFFF_FFFF);

    issue(2'd3, 32'd100, 32'd0);
    wait_done("t3", 1);
    chk("t3_hi", hi, 32'd100);
    chk("t3_lo", lo, 32'hFFFF_FFFF);
    chk("t3_dbz", div_by_zero, 1);

    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("ovf", W + 1);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);
    chk("ovf_dbz", div_by_zero, 0);

    issue(2'd3, 32'd100, 32'd7);
    repeat (4) tick;
    mf_req = 1'b1; mf_sel = 1'b1;
    @(negedge clk);
    chk("t4_stall", stall_req, 1);
    for (int i = 0; i < W + 10; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("t4_idle", busy, 0);
    chk("t4_mf", mf_data, 32'd2);
    chk("t4_lo", lo, 32'd14);
    tick;
    mf_req = 1'b0;

    mt_we = 1'b1; mf_sel = 1'b0; mt_data = 32'h1234;
    tick;
    mt_we = 1'b0;
    @(negedge clk);
    chk("t5_mtlo", lo, 32'h1234);
    tick;
    mt_we = 1'b1; mf_sel = 1'b1; mt_data = 32'hDEAD;
    issue(2'd1, 32'h0001_0000, 32'h0001_0000);
    mt_we = 1'b0;
    wait_done("t5", MUL_LAT);
    chk("t5_hi", hi, 32'h1);
    chk("t5_lo", lo, 32'h0);

    issue(2'd0, 32'd5, 32'd6);
    repeat (10) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    seen = 0;
    @(negedge clk);
    chk("t6_hi", hi, 0);
    chk("t6_lo", lo, 0);
    chk("t6_busy", busy, 0);
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      seen |= done;
    end
    chk("t6_nodone", seen, 0);

    tick;
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom % 4) == 0;
      op      = 2'($urandom);
      src_a   = pick();
      src_b   = (($urandom % 6) == 0) ? '0 : pick();
      mf_req  = ($urandom % 3) == 0;
      mf_sel  = 1'($urandom);
      mt_we   = ($urandom % 5) == 0;
      mt_data = $urandom;
      tick;
    end
    start = 1'b0; mf_req = 1'b0; mt_we = 1'b0;
    repeat (W + 5) tick;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
